uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue and launch controller directly upstream of the UART transmitter.
//  Accepts payload words from system logic (e.g. sum/latch result formatter) via valid/ready,
//  buffers them in a DEPTH-entry FIFO, and issues one single-cycle uart_tx_en pulse per word,
//  only when the transmitter reports idle. Decouples bursty producers from the serial line rate.
// PARAMETERS
//  PAYLOAD_BITS  8   width of each queued word; must match the transmitter payload width
//  DEPTH         16  FIFO entries; power of two, >= 2
// PORTS
//  clk           in   1                  system clock
//  reset         in   1                  synchronous, active-high reset
//  in_valid      in   1                  producer has a word on in_data
//  in_data       in   PAYLOAD_BITS       word to enqueue
//  in_ready      out  1                  FIFO not full; write occurs on in_valid && in_ready
//  uart_tx_busy  in   1                  transmitter busy (high from cycle after en until stop bit done)
//  uart_tx_en    out  1                  one-cycle launch pulse to transmitter
//  uart_tx_data  out  PAYLOAD_BITS       word being launched; held stable until next launch
//  empty         out  1                  FIFO holds no words
//  overflow      out  1                  sticky: in_valid seen while in_ready low
//  level         out  $clog2(DEPTH)+1    occupancy, present only with UART_TXQ_LEVEL_EN
// BEHAVIOUR
//  - Reset (sync, high): rd/wr pointers and count = 0, FSM = S_IDLE, uart_tx_en = 0,
//    uart_tx_data = 0, overflow = 0, empty = 1, in_ready = 1, level = 0. Mid-frame reset
//    flushes all queued words; no pulse issued on the reset cycle or the cycle after.
//  - FIFO: count width $clog2(DEPTH)+1; pointers $clog2(DEPTH) bits, wrap naturally DEPTH-1 -> 0.
//    in_ready = (count != DEPTH); empty = (count == 0); all registered/derived from count only.
//    Push and pop in same cycle: both occur, count unchanged. Push when full is dropped
//    (in_ready low) and sets overflow; FIFO contents and count untouched.
//  - Launch FSM (registered outputs):
//    S_IDLE : if !empty && !uart_tx_busy -> uart_tx_en<=1, uart_tx_data<=head, pop, -> S_ACK
//    S_ACK  : uart_tx_en<=0; if uart_tx_busy -> S_DONE; else stay (waits for busy to rise)
//    S_DONE : if !uart_tx_busy -> S_IDLE; else stay
//  - uart_tx_en is high for exactly one cycle per popped word; never two pulses without an
//    intervening busy high->low sequence.
//  - Latency: word pushed at edge N into empty queue with transmitter idle -> uart_tx_en high
//    after edge N+1 (visible cycle N+1..N+2). Back-to-back: next pulse no earlier than the
//    cycle after busy is observed low in S_DONE.
//  - Word order strictly FIFO; no word lost or duplicated while in_ready honoured.
//  - overflow only clears on reset.
// CONFIGURATION
//  UART_TXQ_LEVEL_EN defined  : port level present, equal to internal count every cycle
//                               (0..DEPTH), updated same edge as push/pop.
//  UART_TXQ_LEVEL_EN undefined: port level absent; all other behaviour identical.
// TESTING
//  1 Reset then idle: no in_valid for 100 cycles -> uart_tx_en never high, empty=1, in_ready=1.
//  2 Single push 8'hA5, busy model rises 1 cycle after en, stays 10 cycles -> one en pulse
//    with uart_tx_data=8'hA5 one cycle after push; empty=1 afterwards.
//  3 Burst 16 pushes 8'h00..8'h0F, busy held high -> in_ready low after 16th, level=16;
//    release busy -> words emitted 00..0F in order, one pulse per busy low period.
//  4 17th push while full (8'hFF) -> overflow=1 and stays 1; 8'hFF never appears on uart_tx_data.
//  5 Simultaneous push/pop at level=3 -> level stays 3, order preserved across pointer wrap.
//  6 reset asserted in S_DONE with 5 queued -> next cycle empty=1, en=0, FSM idle; new push
//    8'h3C after reset is the first word launched.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: DEPTH-entry byte FIFO feeding a UART transmitter.
// Words arrive over valid/ready; a three-state launch FSM issues one
// single-cycle uart_tx_en pulse per word, only while the transmitter is idle,
// and then waits for a full busy rise/fall before the next launch.
// Optional feature: define UART_TXQ_LEVEL_EN to expose the occupancy port "level".
module uart_tx_queue #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH        = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [PAYLOAD_BITS-1:0] in_data,
    output logic                    in_ready,
    input  logic                    uart_tx_busy,
    output logic                    uart_tx_en,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    empty,
    output logic                    overflow
`ifdef UART_TXQ_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_DONE
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    en_nxt;
    logic [PAYLOAD_BITS-1:0] data_nxt;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [CW-1:0]           count;
    logic                    push;
    logic                    pop;

    // Flow-control flags depend on the occupancy counter alone.
    assign in_ready = (count != CW'(DEPTH));
    assign empty    = (count == '0);
    assign push     = in_valid && in_ready;

`ifdef UART_TXQ_LEVEL_EN
    assign level = count;
`endif

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flag: a producer offered a word while the queue was full.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_valid && !in_ready) begin
            overflow <= 1'b1;
        end
    end

    // Launch FSM state and its registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
        end else begin
            state        <= state_nxt;
            uart_tx_en   <= en_nxt;
            uart_tx_data <= data_nxt;
        end
    end

    // Next-state logic: launch from IDLE, wait for busy to rise, then to fall.
    always_comb begin
        state_nxt = state;
        en_nxt    = 1'b0;
        data_nxt  = uart_tx_data;
        pop       = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    en_nxt    = 1'b1;
                    data_nxt  = mem[rd_ptr];
                    pop       = 1'b1;
                    state_nxt = S_ACK;
                end
            end
            S_ACK: begin
                if (uart_tx_busy) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!uart_tx_busy) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: transmitter busy model, scoreboard of launched
// words, a table of burst cases and hand-written corner-case sequences.
module tb_uart_tx_queue;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       uart_tx_busy;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       empty;
    logic       overflow;
`ifdef UART_TXQ_LEVEL_EN
    logic [4:0] level;
`endif

    uart_tx_queue #(.PAYLOAD_BITS(8), .DEPTH(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .uart_tx_busy (uart_tx_busy),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .empty        (empty),
        .overflow     (overflow)
`ifdef UART_TXQ_LEVEL_EN
        ,
        .level        (level)
`endif
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    int         busy_len = 4;
    logic       force_busy = 1'b0;
    int         bcnt = 0;
    logic       prev_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter model: busy rises the cycle after en and lasts busy_len cycles.
    assign uart_tx_busy = force_busy || (bcnt != 0);
    initial begin
        forever begin
            @(posedge clk);
            if (reset) bcnt <= 0;
            else if (uart_tx_en) bcnt <= busy_len;
            else if (bcnt != 0) bcnt <= bcnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard: every launch pulse must carry the oldest accepted word.
    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 1'b0;
            end else begin
                if (uart_tx_en) begin
                    check("en_one_cycle", {31'd0, prev_en}, 32'd0);
                    check("en_while_busy", {31'd0, uart_tx_busy}, 32'd0);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_en: got data %0h expected no pulse", uart_tx_data);
                    end else begin
                        check("tx_data", {24'd0, uart_tx_data}, {24'd0, exp_q.pop_front()});
                    end
                end
                prev_en = uart_tx_en;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // One cycle of in_valid; called and returning on a falling edge.
    task automatic push(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        if (in_ready) exp_q.push_back(d);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_en(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (uart_tx_en) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_en_timeout: got no pulse expected pulse within %0d cycles", budget);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && empty && !uart_tx_busy && !uart_tx_en) begin
                @(negedge clk);
                return;
            end
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: got %0d words pending expected 0", exp_q.size());
    endtask

    typedef struct {
        int         n;
        logic [7:0] base;
        int         blen;
        logic       exp_empty;
        logic       exp_ready;
        logic       exp_ovf;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{n: 1, base: 8'h11, blen: 1, exp_empty: 1'b1, exp_ready: 1'b1, exp_ovf: 1'b0};
        tbl[1] = '{n: 4, base: 8'h20, blen: 3, exp_empty: 1'b1, exp_ready: 1'b1, exp_ovf: 1'b0};
        tbl[2] = '{n: 7, base: 8'hC0, blen: 2, exp_empty: 1'b1, exp_ready: 1'b1, exp_ovf: 1'b0};
        tbl[3] = '{n: 3, base: 8'hFD, blen: 6, exp_empty: 1'b1, exp_ready: 1'b1, exp_ovf: 1'b0};

        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_en", {31'd0, uart_tx_en}, 32'd0);
        check("rst_data", {24'd0, uart_tx_data}, 32'd0);
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
`ifdef UART_TXQ_LEVEL_EN
        check("rst_level", {27'd0, level}, 32'd0);
`endif
        reset = 1'b0;

        // Idle: no words, no pulses for 100 cycles (scoreboard flags any pulse).
        repeat (100) @(negedge clk);
        check("idle_empty", {31'd0, empty}, 32'd1);
        check("idle_ready", {31'd0, in_ready}, 32'd1);

        // Single word: pulse visible the cycle after the push edge.
        busy_len = 10;
        push(8'hA5);
        @(negedge clk);
        check("single_latency_en", {31'd0, uart_tx_en}, 32'd1);
        check("single_data", {24'd0, uart_tx_data}, 32'hA5);
        wait_drain(50);
        check("single_empty", {31'd0, empty}, 32'd1);
        check("single_data_held", {24'd0, uart_tx_data}, 32'hA5);

        // Table of bursts with different transmitter busy lengths.
        for (int t = 0; t < 4; t++) begin
            busy_len = tbl[t].blen;
            for (int i = 0; i < tbl[t].n; i++) push(tbl[t].base + 8'(i));
            wait_drain(200);
            check("tbl_empty", {31'd0, empty}, {31'd0, tbl[t].exp_empty});
            check("tbl_ready", {31'd0, in_ready}, {31'd0, tbl[t].exp_ready});
            check("tbl_ovf", {31'd0, overflow}, {31'd0, tbl[t].exp_ovf});
        end

        // Fill to DEPTH with the transmitter held busy, then offer one more.
        busy_len   = 3;
        force_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'(i));
        check("full_ready", {31'd0, in_ready}, 32'd0);
        check("full_empty", {31'd0, empty}, 32'd0);
`ifdef UART_TXQ_LEVEL_EN
        check("full_level", {27'd0, level}, 32'd16);
`endif
        check("pre_ovf", {31'd0, overflow}, 32'd0);
        push(8'hFF);
        check("ovf_set", {31'd0, overflow}, 32'd1);
        force_busy = 1'b0;
        wait_drain(400);
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        check("burst_empty", {31'd0, empty}, 32'd1);

        // Push and pop on the same edge at occupancy 3, across pointer wrap.
        busy_len   = 4;
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
        force_busy = 1'b0;
        wait_en(20);
`ifdef UART_TXQ_LEVEL_EN
        check("simul_level_start", {27'd0, level}, 32'd3);
`endif
        for (int i = 0; i < 14; i++) begin
            repeat (busy_len + 2) @(negedge clk);
            push(8'h44 + 8'(i));
            check("simul_pop_en", {31'd0, uart_tx_en}, 32'd1);
`ifdef UART_TXQ_LEVEL_EN
            check("simul_level", {27'd0, level}, 32'd3);
`else
            check("simul_not_empty", {31'd0, empty}, 32'd0);
`endif
        end
        wait_drain(200);
        check("simul_empty", {31'd0, empty}, 32'd1);

        // Reset while waiting for busy to fall with five words queued.
        busy_len = 10;
        for (int i = 0; i < 6; i++) push(8'h50 + 8'(i));
        repeat (2) @(negedge clk);
        check("mid_busy", {31'd0, uart_tx_busy}, 32'd1);
        check("mid_not_empty", {31'd0, empty}, 32'd0);
        check("mid_ovf", {31'd0, overflow}, 32'd1);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check("flush_empty", {31'd0, empty}, 32'd1);
        check("flush_en", {31'd0, uart_tx_en}, 32'd0);
        check("flush_ready", {31'd0, in_ready}, 32'd1);
        check("flush_ovf", {31'd0, overflow}, 32'd0);
`ifdef UART_TXQ_LEVEL_EN
        check("flush_level", {27'd0, level}, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_en", {31'd0, uart_tx_en}, 32'd0);
        check("post_rst_empty", {31'd0, empty}, 32'd1);
        push(8'h3C);
        @(negedge clk);
        check("post_rst_launch", {31'd0, uart_tx_en}, 32'd1);
        check("post_rst_data", {24'd0, uart_tx_data}, 32'h3C);
        wait_drain(50);
        check("final_empty", {31'd0, empty}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
